// File: rtl/holo_pkg.sv
// Shared constants and FSM state type for the POV hologram column pipeline.
package holo_pkg;

  localparam int HOLO_LED_COUNT  = 52;
  localparam int HOLO_TEX_WIDTH  = 256;
  localparam int HOLO_NUM_FRAMES = 24;
  localparam int PIX_W           = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/line_buf_ram.sv
// Double line buffer storage: one write port, one registered read port.
// Contents are never reset; the owner masks them until a column is loaded.
module line_buf_ram
  import holo_pkg::*;
#(
  parameter int DEPTH = 2 * HOLO_LED_COUNT,
  parameter int WIDTH = PIX_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/column_prefetch.sv
// Prefetches one texture column into a back line buffer while the strip reads
// the front buffer; banks swap only at a strip start once the back fill is done.
module column_prefetch
  import holo_pkg::*;
#(
  parameter int LED_COUNT  = HOLO_LED_COUNT,
  parameter int TEX_WIDTH  = HOLO_TEX_WIDTH,
  parameter int NUM_FRAMES = HOLO_NUM_FRAMES,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        col,
  input  logic [7:0]        frame_idx,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  input  logic [5:0]        px_num,
  output logic [PIX_W-1:0]  pixel,
  output logic              busy,
  output logic              swap,
  output logic              stale
);

  localparam int IDX_W  = $clog2(LED_COUNT + 1);
  localparam int RAM_AW = $clog2(2 * LED_COUNT);

  localparam logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(TEX_WIDTH * LED_COUNT);
  localparam logic [ADDR_W-1:0] ROW_STRIDE   = ADDR_W'(TEX_WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(LED_COUNT - 1);
  localparam logic [RAM_AW-1:0] BANK_OFFSET  = RAM_AW'(LED_COUNT);
  localparam logic [7:0]        FRAME_LIMIT  = 8'(NUM_FRAMES);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [15:0]         tgt_q, tgt_d;
  logic                tgt_valid_q, tgt_valid_d;
  logic                bank_q, bank_d;
  logic                back_valid_q, back_valid_d;
  logic                front_loaded_q, front_loaded_d;
  logic                stale_q, stale_d;
  logic                swap_q, swap_d;
  logic [5:0]          px_prev_q, px_prev_d;
  logic                pix_ok_q, pix_ok_d;

  logic                target_change;
  logic                strip_start;
  logic [7:0]          eff_frame;
  logic [ADDR_W-1:0]   start_addr;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [RAM_AW-1:0]   wr_addr;
  logic [RAM_AW-1:0]   rd_addr;
  logic                px_in_range;
  logic [PIX_W-1:0]    rd_data;

  // Out-of-range frame indices fall back to frame 0 rather than reading past the ROM.
  assign eff_frame     = (frame_idx >= FRAME_LIMIT) ? 8'd0 : frame_idx;
  assign start_addr    = ADDR_W'(eff_frame) * FRAME_STRIDE + ADDR_W'(col);
  assign target_change = !tgt_valid_q || ({frame_idx, col} != tgt_q);
  assign strip_start   = (px_prev_q != 6'd0) && (px_num == 6'd0);
  assign px_in_range   = RAM_AW'(px_num) < BANK_OFFSET;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    rom_addr_d     = rom_addr_q;
    tgt_d          = tgt_q;
    tgt_valid_d    = tgt_valid_q;
    bank_d         = bank_q;
    back_valid_d   = back_valid_q;
    front_loaded_d = front_loaded_q;
    stale_d        = stale_q;
    swap_d         = 1'b0;
    px_prev_d      = px_num;
    wr_en          = 1'b0;
    wr_idx         = '0;

    case (state_q)
      ST_IDLE: begin
        if (target_change) begin
          state_d      = ST_FETCH;
          tgt_d        = {frame_idx, col};
          tgt_valid_d  = 1'b1;
          idx_d        = '0;
          rom_addr_d   = start_addr;
          back_valid_d = 1'b0;
        end
      end
      ST_FETCH: begin
        // rom_data now holds the word for the address issued last cycle.
        if (idx_q != '0) begin
          wr_en  = 1'b1;
          wr_idx = idx_q - IDX_W'(1);
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          rom_addr_d = rom_addr_q + ROW_STRIDE;
        end
      end
      ST_DRAIN: begin
        wr_en        = 1'b1;
        wr_idx       = LAST_IDX;
        state_d      = ST_IDLE;
        back_valid_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (strip_start) begin
      if (back_valid_q && (state_q == ST_IDLE)) begin
        bank_d         = ~bank_q;
        back_valid_d   = 1'b0;
        swap_d         = 1'b1;
        front_loaded_d = 1'b1;
      end else if (!back_valid_q && ((state_q != ST_IDLE) || target_change)) begin
        stale_d = 1'b1;
      end
    end

    pix_ok_d = px_in_range && front_loaded_d;
  end

  // Bank 0 front means the back half lives at BANK_OFFSET, and vice versa.
  assign wr_addr = bank_q ? RAM_AW'(wr_idx) : (BANK_OFFSET + RAM_AW'(wr_idx));

  // Reading through bank_d lets the first pixel of a new strip see the freshly swapped column.
  always_comb begin
    rd_addr = '0;
    if (px_in_range) begin
      rd_addr = bank_d ? (BANK_OFFSET + RAM_AW'(px_num)) : RAM_AW'(px_num);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      rom_addr_q     <= '0;
      tgt_q          <= '0;
      tgt_valid_q    <= 1'b0;
      bank_q         <= 1'b0;
      back_valid_q   <= 1'b0;
      front_loaded_q <= 1'b0;
      stale_q        <= 1'b0;
      swap_q         <= 1'b0;
      px_prev_q      <= '0;
      pix_ok_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      rom_addr_q     <= rom_addr_d;
      tgt_q          <= tgt_d;
      tgt_valid_q    <= tgt_valid_d;
      bank_q         <= bank_d;
      back_valid_q   <= back_valid_d;
      front_loaded_q <= front_loaded_d;
      stale_q        <= stale_d;
      swap_q         <= swap_d;
      px_prev_q      <= px_prev_d;
      pix_ok_q       <= pix_ok_d;
    end
  end

  line_buf_ram #(
    .DEPTH (2 * LED_COUNT),
    .WIDTH (PIX_W),
    .AW    (RAM_AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (rom_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign rom_addr = rom_addr_q;
  assign busy     = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign swap     = swap_q;
  assign stale    = stale_q;
  assign pixel    = pix_ok_q ? rd_data : '0;

endmodule
